// File: rtl/mini_src_alu_core.sv
// mini_src_alu_core: Mini SRC arithmetic-logic unit feeding the 64-bit Z register.
//   clk       in   1  rising-edge clock (divider only)
//   resetn    in   1  async active-low reset of the divider state
//   x         in  32  operand A / dividend
//   y         in  32  operand B / divisor
//   ALUopp    in  16  one-hot opcode (0 ADD .. 13 INC, 14-15 unused)
//   Z         out 64  result {HI, LO}; HI is zero for 32-bit operations
//   div_done  out  1  DIV result valid on Z
// Everything except DIV is combinational; DIV is a 32-step restoring divider.
module mini_src_alu_core (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic [15:0] ALUopp,
   output logic [63:0] Z,
   output logic        div_done
);

   localparam int unsigned W     = 32;
   localparam int unsigned ZW    = 64;
   localparam int unsigned CW    = 6;
   localparam int unsigned NGRP  = W / 2;

   localparam int unsigned OP_ADD = 0;
   localparam int unsigned OP_SUB = 1;
   localparam int unsigned OP_NEG = 2;
   localparam int unsigned OP_MUL = 3;
   localparam int unsigned OP_DIV = 4;
   localparam int unsigned OP_AND = 5;
   localparam int unsigned OP_OR  = 6;
   localparam int unsigned OP_ROR = 7;
   localparam int unsigned OP_ROL = 8;
   localparam int unsigned OP_SLL = 9;
   localparam int unsigned OP_SRA = 10;
   localparam int unsigned OP_SRL = 11;
   localparam int unsigned OP_NOT = 12;
   localparam int unsigned OP_INC = 13;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } div_state_e;

   // Opcode bits 14-15 have no function.
   logic unused_opc;
   assign unused_opc = ^ALUopp[15:14];

   // ---------------------------------------------------------------- adder
   logic [W-1:0] add_a;
   logic [W-1:0] add_b;
   logic         add_cin;
   logic [W-1:0] add_sum;

   // Shared adder operand selection, NEG > INC > SUB > ADD.
   always_comb begin
      add_a   = x;
      add_b   = y;
      add_cin = 1'b0;
      if (ALUopp[OP_NEG]) begin
         add_a   = '0;
         add_b   = ~x;
         add_cin = 1'b1;
      end else if (ALUopp[OP_INC]) begin
         add_a   = y;
         add_b   = '0;
         add_cin = 1'b1;
      end else if (ALUopp[OP_SUB]) begin
         add_a   = x;
         add_b   = ~y;
         add_cin = 1'b1;
      end
   end

   assign add_sum = add_a + add_b + W'(add_cin);

   // ---------------------------------------------------------- multiplier
   logic [W:0]    booth_ext;
   logic [ZW-1:0] mcand;
   logic [ZW-1:0] pp;
   logic [ZW-1:0] prod;
   logic [2:0]    bgrp;

   // Radix-4 Booth: y recoded into 16 digits in {-2..2}, x is the multiplicand.
   always_comb begin
      booth_ext = {y, 1'b0};
      mcand     = {{W{x[W-1]}}, x};
      prod      = '0;
      pp        = '0;
      bgrp      = '0;
      for (int i = 0; i < int'(NGRP); i++) begin
         bgrp = 3'(booth_ext >> (2 * i));
         case (bgrp)
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = '0 - (mcand << 1);
            3'b101, 3'b110: pp = '0 - mcand;
            default:        pp = '0;
         endcase
         prod = prod + (pp << (2 * i));
      end
   end

   // ------------------------------------------------------------- divider
   div_state_e    state_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  q_q;
   logic [W-1:0]  m_q;
   logic          sx_q;
   logic          sy_q;
   logic          dz_q;
   logic          div_done_q;

   logic [W-1:0]  abs_x;
   logic [W-1:0]  abs_y;
   logic [W:0]    shift_a;
   logic [W:0]    trial;
   logic [W-1:0]  div_quo;
   logic [W-1:0]  div_rem;

   // Magnitudes; 0x80000000 maps onto itself, which is correct as unsigned.
   assign abs_x = x[W-1] ? ('0 - x) : x;
   assign abs_y = y[W-1] ? ('0 - y) : y;

   // One restoring step: shift {A,Q} left, trial-subtract M.
   assign shift_a = {a_q, q_q[W-1]};
   assign trial   = shift_a - {1'b0, m_q};

   // Sign correction; a zero divisor forces an all-ones quotient.
   assign div_quo = dz_q ? '1 : ((sx_q ^ sy_q) ? ('0 - q_q) : q_q);
   assign div_rem = sx_q ? ('0 - a_q) : a_q;

   // Divider FSM; dropping ALUopp[DIV] aborts from any state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         q_q        <= '0;
         m_q        <= '0;
         sx_q       <= 1'b0;
         sy_q       <= 1'b0;
         dz_q       <= 1'b0;
         div_done_q <= 1'b0;
      end else if (!ALUopp[OP_DIV]) begin
         state_q    <= S_IDLE;
         div_done_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               a_q        <= '0;
               q_q        <= abs_x;
               m_q        <= abs_y;
               sx_q       <= x[W-1];
               sy_q       <= y[W-1];
               dz_q       <= (y == '0);
               cnt_q      <= '0;
               div_done_q <= 1'b0;
               state_q    <= S_BUSY;
            end
            S_BUSY: begin
               // trial[W] set means the subtraction went negative: restore.
               a_q   <= trial[W] ? shift_a[W-1:0] : trial[W-1:0];
               q_q   <= {q_q[W-2:0], ~trial[W]};
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(W - 1)) begin
                  state_q    <= S_DONE;
                  div_done_q <= 1'b1;
               end
            end
            S_DONE: begin
               div_done_q <= 1'b1;
            end
            default: begin
               state_q    <= S_IDLE;
               div_done_q <= 1'b0;
            end
         endcase
      end
   end

   assign div_done = div_done_q;

   // ---------------------------------------------------------- result mux
   always_comb begin
      Z = '0;
      if (ALUopp[OP_ADD] | ALUopp[OP_SUB] | ALUopp[OP_NEG] | ALUopp[OP_INC]) begin
         Z = {{W{1'b0}}, add_sum};
      end else if (ALUopp[OP_MUL]) begin
         Z = prod;
      end else if (ALUopp[OP_DIV]) begin
         Z = div_done_q ? {div_rem, div_quo} : '0;
      end else if (ALUopp[OP_AND]) begin
         Z = {{W{1'b0}}, x & y};
      end else if (ALUopp[OP_OR]) begin
         Z = {{W{1'b0}}, x | y};
      end else if (ALUopp[OP_ROR]) begin
         Z = {{W{1'b0}}, x[0], x[W-1:1]};
      end else if (ALUopp[OP_ROL]) begin
         Z = {{W{1'b0}}, x[W-2:0], x[W-1]};
      end else if (ALUopp[OP_SLL]) begin
         Z = {{W{1'b0}}, x[W-2:0], 1'b0};
      end else if (ALUopp[OP_SRA]) begin
         Z = {{W{1'b0}}, x[W-1], x[W-1:1]};
      end else if (ALUopp[OP_SRL]) begin
         Z = {{W{1'b0}}, 1'b0, x[W-1:1]};
      end else if (ALUopp[OP_NOT]) begin
         Z = {{W{1'b0}}, ~x};
      end
   end

endmodule

// File: tb/tb_mini_src_alu_core.sv
// tb_mini_src_alu_core: directed and randomized checks of mini_src_alu_core
// against an arithmetic reference model.
module tb_mini_src_alu_core;

   logic        clk;
   logic        resetn;
   logic [31:0] x;
   logic [31:0] y;
   logic [15:0] ALUopp;
   logic [63:0] Z;
   logic        div_done;

   int checks;
   int errors;

   localparam logic [15:0] OPC_DIV = 16'h0010;

   mini_src_alu_core dut (
      .clk      (clk),
      .resetn   (resetn),
      .x        (x),
      .y        (y),
      .ALUopp   (ALUopp),
      .Z        (Z),
      .div_done (div_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference for every non-DIV opcode vector (DIV in progress reads as 0).
   function automatic logic [63:0] ref_comb(input logic [15:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] r;
      longint      p;
      r = 32'h0;
      if (op[0] || op[1] || op[2] || op[13]) begin
         if (op[2])       r = 32'h0 - a;
         else if (op[13]) r = b + 32'h1;
         else if (op[1])  r = a - b;
         else             r = a + b;
      end else if (op[3]) begin
         p = longint'($signed(a)) * longint'($signed(b));
         return p;
      end else if (op[4])  r = 32'h0;
      else if (op[5])      r = a & b;
      else if (op[6])      r = a | b;
      else if (op[7])      r = (a >> 1) | (a << 31);
      else if (op[8])      r = (a << 1) | (a >> 31);
      else if (op[9])      r = a << 1;
      else if (op[10])     r = $signed(a) >>> 1;
      else if (op[11])     r = a >> 1;
      else if (op[12])     r = ~a;
      return {32'h0, r};
   endfunction

   // Signed division reference using 64-bit arithmetic: {remainder, quotient}.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      longint da;
      longint db;
      logic [31:0] q;
      logic [31:0] r;
      da = longint'($signed(a));
      db = longint'($signed(b));
      if (b == 32'h0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else begin
         q = 32'(da / db);
         r = 32'(da % db);
      end
      return {r, q};
   endfunction

   task automatic test_reset();
      resetn = 1'b0;
      ALUopp = 16'h0;
      x      = 32'h0;
      y      = 32'h0;
      #1;
      checks++;
      if (div_done !== 1'b0 || Z !== 64'h0) begin
         errors++;
         $display("FAIL reset_idle: done=%b Z=%h expected done=0 Z=0", div_done, Z);
      end
      ALUopp = OPC_DIV;
      x      = 32'd20;
      y      = 32'd5;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (div_done !== 1'b0 || Z !== 64'h0) begin
         errors++;
         $display("FAIL reset_div_held: done=%b Z=%h expected done=0 Z=0", div_done, Z);
      end
      @(negedge clk);
      ALUopp = 16'h0;
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed_comb();
      logic [15:0] ops [17];
      logic [31:0] xs  [17];
      logic [31:0] ys  [17];
      logic [63:0] exp [17];
      ops = '{16'h0001, 16'h0002, 16'h0004, 16'h2000, 16'h0008, 16'h0008, 16'h0008,
              16'h0020, 16'h0040, 16'h1000, 16'h0080, 16'h0100, 16'h0200, 16'h0400,
              16'h0800, 16'h0000, 16'h0003};
      xs  = '{32'd10, 32'd15, 32'd7, 32'd0, 32'd4, 32'hFFFF_FFFE, 32'h8000_0000,
              32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hAAAA_AAAA, 32'h8000_0001, 32'h4000_0000,
              32'h1, 32'h8000_0000, 32'h8000_0000, 32'h1234, 32'd9};
      ys  = '{32'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd3, 32'd3, 32'h8000_0000,
              32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0, 32'd2, 32'd2, 32'd2, 32'd2,
              32'd2, 32'h5678, 32'd4};
      exp = '{64'd15, 64'd10, 64'h0000_0000_FFFF_FFF9, 64'h0, 64'd12,
              64'hFFFF_FFFF_FFFF_FFFA, 64'h4000_0000_0000_0000, 64'h0,
              64'h0000_0000_FFFF_FFFF, 64'h0000_0000_5555_5555, 64'h0000_0000_C000_0000,
              64'h0000_0000_8000_0000, 64'd2, 64'h0000_0000_C000_0000,
              64'h0000_0000_4000_0000, 64'h0, 64'd5};
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         ALUopp = ops[i];
         x      = xs[i];
         y      = ys[i];
         #1;
         checks++;
         if (Z !== exp[i]) begin
            errors++;
            $display("FAIL directed_comb[%0d] op=%h: Z=%h expected %h", i, ops[i], Z, exp[i]);
         end
      end
   endtask

   task automatic test_random_comb();
      logic [15:0] op;
      logic [63:0] exp;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (i % 3 == 0) op = 16'($urandom) & ~OPC_DIV;
         else begin
            op = 16'h1 << $urandom_range(15, 0);
            if (op == OPC_DIV) op = 16'h0008;
         end
         ALUopp = op;
         x      = $urandom;
         y      = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
         #1;
         exp = ref_comb(op, x, y);
         checks++;
         if (Z !== exp) begin
            errors++;
            $display("FAIL random_comb op=%h x=%h y=%h: Z=%h expected %h", op, x, y, Z, exp);
         end
      end
      @(negedge clk);
      ALUopp = 16'h0;
   endtask

   // Runs one full divide from IDLE, scrambling operands after the latch edge.
   task automatic test_div(input logic [31:0] dx, input logic [31:0] dy);
      logic [63:0] exp;
      exp = ref_div(dx, dy);
      @(negedge clk);
      ALUopp = OPC_DIV;
      x      = dx;
      y      = dy;
      for (int e = 0; e < 32; e++) begin
         @(posedge clk);
         #1;
         checks++;
         if (div_done !== 1'b0 || Z !== 64'h0) begin
            errors++;
            $display("FAIL div_busy %h/%h edge=%0d: done=%b Z=%h expected done=0 Z=0",
                     dx, dy, e, div_done, Z);
         end
         if (e == 0) begin
            x = $urandom;
            y = $urandom;
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (div_done !== 1'b1 || Z !== exp) begin
         errors++;
         $display("FAIL div_result %h/%h: done=%b Z=%h expected done=1 Z=%h",
                  dx, dy, div_done, Z, exp);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (div_done !== 1'b1 || Z !== exp) begin
         errors++;
         $display("FAIL div_hold %h/%h: done=%b Z=%h expected done=1 Z=%h",
                  dx, dy, div_done, Z, exp);
      end
      @(negedge clk);
      ALUopp = 16'h0;
      @(posedge clk);
      #1;
      checks++;
      if (div_done !== 1'b0) begin
         errors++;
         $display("FAIL div_release %h/%h: done=%b expected 0", dx, dy, div_done);
      end
   endtask

   task automatic test_div_directed();
      test_div(32'd20, 32'd5);
      test_div(32'hFFFF_FFF9, 32'd2);
      test_div(32'd7, 32'd0);
      test_div(32'hFFFF_FFF9, 32'd0);
      test_div(32'h8000_0000, 32'hFFFF_FFFF);
      test_div(32'd100, 32'hFFFF_FFF9);
      test_div(32'hFFFF_FF9C, 32'hFFFF_FFF9);
      test_div(32'd0, 32'd5);
   endtask

   task automatic test_div_random();
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) test_div($urandom, $urandom);
         else            test_div($urandom, 32'($urandom_range(300, 0)) - 32'd150);
      end
   endtask

   task automatic test_div_abort();
      @(negedge clk);
      ALUopp = OPC_DIV;
      x      = 32'h0001_2345;
      y      = 32'd7;
      repeat (11) @(posedge clk);
      @(negedge clk);
      ALUopp = 16'h0;
      @(posedge clk);
      #1;
      checks++;
      if (div_done !== 1'b0 || Z !== 64'h0) begin
         errors++;
         $display("FAIL div_abort: done=%b Z=%h expected done=0 Z=0", div_done, Z);
      end
      test_div(32'd100, 32'd10);
   endtask

   task automatic test_div_reset();
      // Reset while busy.
      @(negedge clk);
      ALUopp = OPC_DIV;
      x      = 32'd1000;
      y      = 32'd3;
      repeat (15) @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (div_done !== 1'b0 || Z !== 64'h0) begin
         errors++;
         $display("FAIL div_reset_busy: done=%b Z=%h expected done=0 Z=0", div_done, Z);
      end
      @(negedge clk);
      ALUopp = 16'h0;
      resetn = 1'b1;
      test_div(32'd100, 32'd10);
      // Reset while DONE must drop div_done without a clock edge.
      @(negedge clk);
      ALUopp = OPC_DIV;
      x      = 32'd77;
      y      = 32'd7;
      repeat (34) @(posedge clk);
      #2;
      checks++;
      if (div_done !== 1'b1 || Z !== ref_div(32'd77, 32'd7)) begin
         errors++;
         $display("FAIL div_pre_reset: done=%b Z=%h expected done=1 Z=%h",
                  div_done, Z, ref_div(32'd77, 32'd7));
      end
      resetn = 1'b0;
      #1;
      checks++;
      if (div_done !== 1'b0 || Z !== 64'h0) begin
         errors++;
         $display("FAIL div_reset_done: done=%b Z=%h expected done=0 Z=0", div_done, Z);
      end
      @(negedge clk);
      ALUopp = 16'h0;
      resetn = 1'b1;
      test_div(32'd100, 32'd10);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      resetn = 1'b0;
      ALUopp = 16'h0;
      x      = 32'h0;
      y      = 32'h0;
      test_reset();
      test_directed_comb();
      test_random_comb();
      test_div_directed();
      test_div_random();
      test_div_abort();
      test_div_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
